// File: rtl/wb_gpio_pkg.sv
// Shared constants, register decode and lane helpers for the Wishbone GPIO bank.
package wb_gpio_pkg;

    localparam int unsigned WIN_BITS = 5;
    localparam int unsigned WB_DW    = 32;

    localparam logic [WIN_BITS-1:0] OFS_OUT     = 5'h00;
    localparam logic [WIN_BITS-1:0] OFS_OEB     = 5'h04;
    localparam logic [WIN_BITS-1:0] OFS_IN      = 5'h08;
    localparam logic [WIN_BITS-1:0] OFS_RISE_EN = 5'h0C;
    localparam logic [WIN_BITS-1:0] OFS_FALL_EN = 5'h10;
    localparam logic [WIN_BITS-1:0] OFS_STATUS  = 5'h14;
    localparam logic [WIN_BITS-1:0] OFS_MASK    = 5'h18;

    // Register select shared by the read mux and the write strobes.
    typedef enum logic [2:0] {
        RD_OUT     = 3'd0,
        RD_OEB     = 3'd1,
        RD_IN      = 3'd2,
        RD_RISE_EN = 3'd3,
        RD_FALL_EN = 3'd4,
        RD_STATUS  = 3'd5,
        RD_MASK    = 3'd6,
        RD_RSVD    = 3'd7
    } rd_sel_e;

    // Word-aligned offset to register select; the byte-within-word bits are ignored.
    function automatic rd_sel_e decode_ofs(input logic [WIN_BITS-1:0] ofs);
        rd_sel_e sel;
        sel = RD_RSVD;
        case (ofs & 5'b11100)
            OFS_OUT:     sel = RD_OUT;
            OFS_OEB:     sel = RD_OEB;
            OFS_IN:      sel = RD_IN;
            OFS_RISE_EN: sel = RD_RISE_EN;
            OFS_FALL_EN: sel = RD_FALL_EN;
            OFS_STATUS:  sel = RD_STATUS;
            OFS_MASK:    sel = RD_MASK;
            default:     sel = RD_RSVD;
        endcase
        return sel;
    endfunction

    // Expand the four byte selects into a 32-bit lane mask.
    function automatic logic [WB_DW-1:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchroniser with a history flop for edge detection.
module gpio_sync_edge
    import wb_gpio_pkg::*;
#(
    parameter int unsigned W = 17
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_c_o,
    output logic [W-1:0] fall_c_o
);

    logic [W-1:0] sync1_q, sync2_q, prev_q;
    logic [W-1:0] sync1_d, sync2_d, prev_d;

    // Next state: shift the pad value down the chain each cycle.
    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and history flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o   = sync2_q;
    assign rise_c_o = sync2_q & ~prev_q;
    assign fall_c_o = ~sync2_q & prev_q;

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: output/enable registers, synchronised input readback,
// per-pad edge status with masking, and IRQ reduction onto NIRQ lines.
module wb_gpio_bank
    import wb_gpio_pkg::*;
#(
    parameter int unsigned NPADS     = 17,
    parameter int unsigned NIRQ      = 3,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPADS-1:0] io_in,
    output logic [NPADS-1:0] io_out,
    output logic [NPADS-1:0] io_oeb,
    output logic [NIRQ-1:0]  irq_o
);

    logic [NPADS-1:0] out_q, oeb_q, rise_en_q, fall_en_q, status_q, mask_q;
    logic [NPADS-1:0] out_d, oeb_d, rise_en_d, fall_en_d, status_d, mask_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic [NIRQ-1:0]  irq_q, irq_d;

    logic [NPADS-1:0] in_sync_c, rise_c, fall_c, set_c, clr_c, pend_c;
    logic [NPADS-1:0] wmask_c, wdat_c;
    logic [31:0]      lane_c, rdata_c;
    logic             hit_c, req_c, wr_c;
    rd_sel_e          reg_sel_c;
    logic             unused_adr;

    // Input synchronisation and edge detection for every pad.
    gpio_sync_edge #(
        .W (NPADS)
    ) u_sync (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .async_i  (io_in),
        .sync_o   (in_sync_c),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    // Address decode; a request is blocked while ack is high so ack never stays up two cycles.
    always_comb begin
        hit_c     = (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
        req_c     = wbs_cyc_i & wbs_stb_i & hit_c & ~ack_q;
        wr_c      = req_c & wbs_we_i;
        reg_sel_c = decode_ofs(wbs_adr_i[WIN_BITS-1:0]);
        lane_c    = byte_mask(wbs_sel_i);
        wmask_c   = NPADS'(lane_c);
        wdat_c    = NPADS'(wbs_dat_i & lane_c);
    end

    assign unused_adr = ^wbs_adr_i[1:0];

    // Register file next state, including W1C status where a new edge beats a clear.
    always_comb begin
        out_d     = out_q;
        oeb_d     = oeb_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        clr_c     = '0;
        set_c     = (rise_c & rise_en_q) | (fall_c & fall_en_q);
        if (wr_c) begin
            case (reg_sel_c)
                RD_OUT:     out_d     = (out_q & ~wmask_c) | wdat_c;
                RD_OEB:     oeb_d     = (oeb_q & ~wmask_c) | wdat_c;
                RD_RISE_EN: rise_en_d = (rise_en_q & ~wmask_c) | wdat_c;
                RD_FALL_EN: fall_en_d = (fall_en_q & ~wmask_c) | wdat_c;
                RD_MASK:    mask_d    = (mask_q & ~wmask_c) | wdat_c;
                RD_STATUS:  clr_c     = wdat_c;
                default:    ;
            endcase
        end
        status_d = (status_q & ~clr_c) | set_c;
    end

    // Read mux; live bits zero-extended to the bus width.
    always_comb begin
        rdata_c = '0;
        case (reg_sel_c)
            RD_OUT:     rdata_c = 32'(out_q);
            RD_OEB:     rdata_c = 32'(oeb_q);
            RD_IN:      rdata_c = 32'(in_sync_c);
            RD_RISE_EN: rdata_c = 32'(rise_en_q);
            RD_FALL_EN: rdata_c = 32'(fall_en_q);
            RD_STATUS:  rdata_c = 32'(status_q);
            RD_MASK:    rdata_c = 32'(mask_q);
            default:    rdata_c = '0;
        endcase
    end

    // Bus response: one-cycle ack, read data presented alongside it.
    always_comb begin
        ack_d = req_c;
        dat_d = (req_c && !wbs_we_i) ? rdata_c : '0;
    end

    // IRQ reduction: pad i contributes to line i % NIRQ.
    always_comb begin
        pend_c = status_q & mask_q;
        irq_d  = '0;
        for (int j = 0; j < int'(NIRQ); j++) begin
            for (int i = 0; i < int'(NPADS); i++) begin
                if ((i % int'(NIRQ)) == j) begin
                    irq_d[j] = irq_d[j] | pend_c[i];
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q     <= '0;
            oeb_q     <= '1;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= '0;
        end else begin
            out_q     <= out_d;
            oeb_q     <= oeb_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = out_q;
    assign io_oeb    = oeb_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Self-checking bench for wb_gpio_bank with default parameters.
module tb_wb_gpio_bank;

    localparam int unsigned NP   = 17;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] LIVE = 32'h0001_FFFF;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_ni;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic          ack;
    logic [31:0]   rdat;
    logic [NP-1:0] io_in, io_out, io_oeb;
    logic [2:0]    irq;

    int n_checks = 0;
    int n_fail   = 0;

    wb_gpio_bank dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq_o     (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        exp_ack;
        logic [31:0] exp_rdat;
    } vec_t;

    vec_t vecs[16];

    // behavioural register model for the random phase
    logic [31:0] m_out, m_oeb, m_rise, m_fall, m_status, m_mask, m_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic [31:0] a, input logic w, input logic [3:0] s,
                             input logic [31:0] d, output logic got, output logic [31:0] rd,
                             output int lat);
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        got = 1'b0; rd = '0; lat = 0;
        while (!got && lat < 8) begin
            @(negedge wb_clk_i);
            lat++;
            if (ack) begin
                got = 1'b1;
                rd  = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s);
        logic g; logic [31:0] r; int l;
        wb_access(BASE + 32'(ofs), 1'b1, s, d, g, r, l);
        check($sformatf("wr_ack_%h", ofs), 32'(g), 32'd1);
    endtask

    task automatic rd(input logic [7:0] ofs, output logic [31:0] r);
        logic g; int l;
        wb_access(BASE + 32'(ofs), 1'b0, 4'hF, 32'd0, g, r, l);
        check($sformatf("rd_ack_%h", ofs), 32'(g), 32'd1);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic logic [2:0] model_irq(input logic [31:0] st, input logic [31:0] mk);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < int'(NP); i++) if (st[i] && mk[i]) r[i % 3] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] ofs);
        case (ofs)
            8'h00:   return m_out;
            8'h04:   return m_oeb;
            8'h08:   return m_in;
            8'h0C:   return m_rise;
            8'h10:   return m_fall;
            8'h14:   return m_status;
            8'h18:   return m_mask;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic        g;
        logic [31:0] r, rin;
        int          l;
        logic [5:0]  ack_pat;
        logic [2:0]  irq_hist;

        vecs[0]  = '{BASE + 32'h00, 1'b1, 4'b0001, 32'h0000_5A5A, 1'b1, 32'h0};
        vecs[1]  = '{BASE + 32'h00, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h0000_005A};
        vecs[2]  = '{BASE + 32'h00, 1'b1, 4'b0011, 32'hFFFF_A5A5, 1'b1, 32'h0};
        vecs[3]  = '{BASE + 32'h00, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h0000_A5A5};
        vecs[4]  = '{BASE + 32'h00, 1'b1, 4'b0100, 32'h00FF_0000, 1'b1, 32'h0};
        vecs[5]  = '{BASE + 32'h00, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h0001_A5A5};
        vecs[6]  = '{BASE + 32'h18, 1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[7]  = '{BASE + 32'h18, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h0001_FFFF};
        vecs[8]  = '{BASE + 32'h1C, 1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[9]  = '{BASE + 32'h1C, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h0};
        vecs[10] = '{BASE + 32'h20, 1'b0, 4'b1111, 32'h0,         1'b0, 32'h0};
        vecs[11] = '{BASE + 32'h20, 1'b1, 4'b1111, 32'h1234_5678, 1'b0, 32'h0};
        vecs[12] = '{BASE + 32'h08, 1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[13] = '{BASE + 32'h18, 1'b1, 4'b1111, 32'h0,         1'b1, 32'h0};
        vecs[14] = '{BASE + 32'h18, 1'b0, 4'b1111, 32'h0,         1'b1, 32'h0};
        vecs[15] = '{32'h2000_0000, 1'b0, 4'b1111, 32'h0,         1'b0, 32'h0};

        // reset state
        wb_rst_ni = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        rin   = $urandom & LIVE;
        io_in = NP'(rin);
        repeat (3) @(negedge wb_clk_i);
        check("rst_oeb", 32'(io_oeb), LIVE);
        check("rst_out", 32'(io_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        wb_rst_ni = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        rd(8'h08, r);
        check("rst_in_readback", r, rin);

        // table-driven register accesses
        for (int i = 0; i < 16; i++) begin
            wb_access(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].wdat, g, r, l);
            check($sformatf("vec%0d_ack", i), 32'(g), 32'(vecs[i].exp_ack));
            if (vecs[i].exp_ack) check($sformatf("vec%0d_lat", i), 32'(l), 32'd1);
            if (vecs[i].exp_ack && !vecs[i].we) check($sformatf("vec%0d_rdat", i), r, vecs[i].exp_rdat);
            if (i == 0) check("io_out_5a", 32'(io_out), 32'h5A);
        end
        check("io_out_final", 32'(io_out), 32'h1_A5A5);

        // stb held high: ack must pulse every other cycle
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h08; sel = 4'hF;
        ack_pat = '0;
        for (int c = 5; c >= 0; c--) begin
            @(negedge wb_clk_i);
            ack_pat[c] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check("ack_held_pattern", 32'(ack_pat), 32'b101010);

        // rising edge on pad 4 -> status and irq_o[1] latency, then W1C
        io_in = '0;
        repeat (5) @(negedge wb_clk_i);
        wr(8'h14, LIVE, 4'hF);
        wr(8'h0C, 32'h11, 4'hF);
        wr(8'h18, 32'h11, 4'hF);
        @(negedge wb_clk_i);
        io_in[4] = 1'b1;
        irq_hist = '0;
        repeat (3) @(negedge wb_clk_i);
        irq_hist[0] = irq[1];
        @(negedge wb_clk_i);
        irq_hist[1] = irq[1];
        check("irq1_latency", 32'(irq_hist[1:0]), 32'b10);
        rd(8'h14, r);
        check("status_rise4", r, 32'h10);
        wr(8'h14, 32'h10, 4'b0001);
        check("irq1_after_clear_hold", 32'(irq[1]), 32'd1);
        @(negedge wb_clk_i);
        check("irq1_after_clear", 32'(irq[1]), 32'd0);
        rd(8'h14, r);
        check("status_cleared", r, 32'h0);

        // set and W1C on the same edge: set wins
        @(negedge wb_clk_i);
        io_in[0] = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        check("irq0_first_rise", 32'(irq[0]), 32'd1);
        io_in[0] = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        io_in[0] = 1'b1;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h14; sel = 4'b0001; wdat = 32'h1;
        @(negedge wb_clk_i);
        check("conflict_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        irq_hist[0] = irq[0];
        @(negedge wb_clk_i);
        irq_hist[1] = irq[0];
        @(negedge wb_clk_i);
        irq_hist[2] = irq[0];
        check("conflict_irq0", 32'(irq_hist), 32'b111);
        rd(8'h14, r);
        check("conflict_status", r, 32'h1);

        // reset asserted during the ack cycle of an OEB write
        @(negedge wb_clk_i);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; sel = 4'hF; wdat = 32'h0;
        @(posedge wb_clk_i);
        #1;
        check("oeb_written", 32'(io_oeb), 32'd0);
        check("oeb_ack", 32'(ack), 32'd1);
        wb_rst_ni = 1'b0;
        #1;
        check("midrst_oeb", 32'(io_oeb), LIVE);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_out", 32'(io_out), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        rd(8'h04, r);
        check("midrst_oeb_read", r, LIVE);

        // randomized traffic against the behavioural model
        m_out = '0; m_oeb = LIVE; m_rise = '0; m_fall = '0; m_status = '0; m_mask = '0;
        m_in = 32'(io_in);
        for (int it = 0; it < 40; it++) begin
            logic [31:0] d, bm, nin;
            logic [3:0]  s;
            logic [7:0]  ofs;
            int          k;
            d  = $urandom;
            s  = 4'($urandom_range(15, 0));
            bm = lanes(s) & LIVE;
            k  = int'($urandom_range(5, 0));
            case (k)
                0: begin ofs = 8'h00; m_out  = (m_out  & ~bm) | (d & bm); end
                1: begin ofs = 8'h04; m_oeb  = (m_oeb  & ~bm) | (d & bm); end
                2: begin ofs = 8'h0C; m_rise = (m_rise & ~bm) | (d & bm); end
                3: begin ofs = 8'h10; m_fall = (m_fall & ~bm) | (d & bm); end
                4: begin ofs = 8'h14; m_status = m_status & ~(d & bm); end
                default: begin ofs = 8'h18; m_mask = (m_mask & ~bm) | (d & bm); end
            endcase
            wr(ofs, d, s);
            check($sformatf("rnd%0d_io_out", it), 32'(io_out), m_out);
            check($sformatf("rnd%0d_io_oeb", it), 32'(io_oeb), m_oeb);
            nin = $urandom & LIVE;
            io_in = NP'(nin);
            m_status = m_status | (nin & ~m_in & m_rise) | (~nin & m_in & m_fall & LIVE);
            m_in = nin;
            repeat (5) @(negedge wb_clk_i);
            check($sformatf("rnd%0d_irq", it), 32'(irq), 32'(model_irq(m_status, m_mask)));
            ofs = 8'(4 * $urandom_range(7, 0));
            rd(ofs, r);
            check($sformatf("rnd%0d_rd_%h", it, ofs), r, model_read(ofs));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
